// File: rtl/dcp_run_ctrl.sv
// dcp_run_ctrl: CPU run/step controller for the debug control panel.
//   Generates a gated cpu_clk for single-step, N-step and free-run operation.
//   Holds NBP PC breakpoints and reports why a sequence stopped.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   cmd_vld/cmd_rdy           command handshake from the parser
//   cmd_op/cmd_idx/cmd_arg    opcode, breakpoint index, argument
//   pc                        current CPU PC
//   cpu_clk                   registered gated CPU clock (1 clk high per instr)
//   running                   high during a STEP/RUN sequence
//   stop_vld/stop_cause/bp_idx  end-of-sequence pulse, cause, hit index
//   bp_en                     breakpoint enable vector
//   cmd_err                   pulse on an illegal op or out-of-range index
//   cyc_cnt                   count of cpu_clk pulses issued

// One breakpoint slot: address register, enable bit, hit compare.
module dcp_bp_slot #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          set,
  input  logic          clr,
  input  logic [AW-1:0] arg,
  input  logic [AW-1:0] pc,
  output logic          en,
  output logic          hit
);
  logic [AW-1:0] addr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr <= '0;
      en   <= 1'b0;
    end else if (set) begin
      addr <= arg;
      en   <= 1'b1;
    end else if (clr) begin
      en   <= 1'b0;
    end
  end

  assign hit = en && (pc == addr);
endmodule

module dcp_run_ctrl #(
  parameter int NBP = 4,
  parameter int AW  = 32,
  parameter int CW  = 16,
  parameter int IW  = 2
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  input  logic [2:0]     cmd_op,
  input  logic [IW-1:0]  cmd_idx,
  input  logic [AW-1:0]  cmd_arg,
  input  logic [AW-1:0]  pc,
  output logic           cpu_clk,
  output logic           running,
  output logic           stop_vld,
  output logic [1:0]     stop_cause,
  output logic [IW-1:0]  bp_idx,
  output logic [NBP-1:0] bp_en,
  output logic           cmd_err,
  output logic [31:0]    cyc_cnt
);
  localparam logic [2:0] OP_NOP = 3'd0, OP_STEP = 3'd1, OP_RUN = 3'd2, OP_HALT = 3'd3,
                         OP_SETBP = 3'd4, OP_CLRBP = 3'd5, OP_CLRALL = 3'd6;
  localparam logic [1:0] C_STEP = 2'd1, C_BP = 2'd2, C_HALT = 2'd3;

  typedef enum logic [1:0] {IDLE, PULSE, CHECK, STOP} state_t;

  state_t        state, nxt;
  logic [1:0]    nxt_cause;
  logic [CW-1:0] cnt;
  logic          step_mode;
  logic          acc, idx_ok, in_idle, any_hit;
  logic [NBP-1:0] hit, set_v, clr_v;
  logic [IW-1:0] hit_idx;

  assign acc     = cmd_vld && cmd_rdy;
  assign in_idle = (state == IDLE);
  assign idx_ok  = (32'(cmd_idx) < NBP);

  // Breakpoint slots; writes only land from IDLE, so a mid-run SETBP is dropped.
  genvar i;
  generate
    for (i = 0; i < NBP; i++) begin : g_bp
      assign set_v[i] = acc && in_idle && (cmd_op == OP_SETBP) && idx_ok && (cmd_idx == IW'(i));
      assign clr_v[i] = acc && in_idle &&
                        (((cmd_op == OP_CLRBP) && idx_ok && (cmd_idx == IW'(i))) ||
                         (cmd_op == OP_CLRALL));
      dcp_bp_slot #(.AW(AW)) u_slot (
        .clk (clk),
        .rstn(rstn),
        .set (set_v[i]),
        .clr (clr_v[i]),
        .arg (cmd_arg),
        .pc  (pc),
        .en  (bp_en[i]),
        .hit (hit[i])
      );
    end
  endgenerate

  assign any_hit = |hit;

  // Lowest hit index wins: scan downward so the last assignment is the lowest.
  always_comb begin
    hit_idx = '0;
    for (int k = NBP - 1; k >= 0; k--)
      if (hit[k]) hit_idx = IW'(k);
  end

  always_comb begin
    nxt       = state;
    nxt_cause = stop_cause;
    case (state)
      IDLE: if (acc) begin
        case (cmd_op)
          OP_STEP, OP_RUN: nxt = PULSE;
          OP_HALT: begin nxt = STOP; nxt_cause = C_HALT; end
          default: nxt = IDLE;
        endcase
      end
      PULSE: nxt = CHECK;
      CHECK: begin
        if (acc && (cmd_op == OP_HALT)) begin
          nxt = STOP; nxt_cause = C_HALT;
        end else if (any_hit) begin
          nxt = STOP; nxt_cause = C_BP;
        end else if (step_mode && (cnt == '0)) begin
          nxt = STOP; nxt_cause = C_STEP;
        end else begin
          nxt = PULSE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // All outputs are registered; cmd_rdy tracks the state being entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cmd_rdy    <= 1'b0;
      cpu_clk    <= 1'b0;
      running    <= 1'b0;
      stop_vld   <= 1'b0;
      stop_cause <= 2'd0;
      bp_idx     <= '0;
      cmd_err    <= 1'b0;
      cyc_cnt    <= '0;
      cnt        <= '0;
      step_mode  <= 1'b0;
    end else begin
      state    <= nxt;
      cmd_rdy  <= (nxt == IDLE) || (nxt == CHECK);
      cpu_clk  <= (nxt == PULSE);
      stop_vld <= (nxt == STOP);
      cmd_err  <= 1'b0;
      if (nxt == STOP) begin
        running    <= 1'b0;
        stop_cause <= nxt_cause;
        if (nxt_cause == C_BP) bp_idx <= hit_idx;
      end
      case (state)
        IDLE: if (acc) begin
          case (cmd_op)
            OP_STEP: begin
              cnt       <= (cmd_arg[CW-1:0] == '0) ? CW'(1) : cmd_arg[CW-1:0];
              step_mode <= 1'b1;
              running   <= 1'b1;
            end
            OP_RUN: begin
              step_mode <= 1'b0;
              running   <= 1'b1;
            end
            OP_SETBP, OP_CLRBP: if (!idx_ok) cmd_err <= 1'b1;
            OP_CLRALL: cyc_cnt <= '0;
            OP_NOP, OP_HALT: ;
            default: cmd_err <= 1'b1;
          endcase
        end
        PULSE: begin
          cyc_cnt <= cyc_cnt + 32'd1;
          if (step_mode) cnt <= cnt - CW'(1);
        end
        CHECK: if (acc && (cmd_op != OP_HALT)) cmd_err <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dcp_run_ctrl.sv
module tb_dcp_run_ctrl;
  localparam int NBP = 3, AW = 32, CW = 16, IW = 2;
  localparam logic [2:0] OP_STEP = 3'd1, OP_RUN = 3'd2, OP_HALT = 3'd3,
                         OP_SETBP = 3'd4, OP_CLRBP = 3'd5, OP_CLRALL = 3'd6, OP_RSVD = 3'd7;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic           cmd_vld = 1'b0, cmd_rdy;
  logic [2:0]     cmd_op = '0;
  logic [IW-1:0]  cmd_idx = '0;
  logic [AW-1:0]  cmd_arg = '0, pc = '0;
  logic           cpu_clk, running, stop_vld, cmd_err;
  logic [1:0]     stop_cause;
  logic [IW-1:0]  bp_idx;
  logic [NBP-1:0] bp_en;
  logic [31:0]    cyc_cnt;

  dcp_run_ctrl #(.NBP(NBP), .AW(AW), .CW(CW), .IW(IW)) dut (
    .clk(clk), .rstn(rstn), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .pc(pc), .cpu_clk(cpu_clk), .running(running),
    .stop_vld(stop_vld), .stop_cause(stop_cause), .bp_idx(bp_idx), .bp_en(bp_en),
    .cmd_err(cmd_err), .cyc_cnt(cyc_cnt)
  );

  typedef struct { logic [1:0] cause; logic [IW-1:0] idx; int pulses; } exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0;
  int npulse = 0;
  bit pend = 0, dbl = 0;

  // One clock: CPU model advances pc by 4 after each cpu_clk pulse; outputs
  // are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pend) pc = pc + 32'd4;
    @(negedge clk);
    if (pend && cpu_clk) dbl = 1;
    pend = cpu_clk;
    if (cpu_clk) npulse++;
  endtask

  task automatic send(input logic [2:0] op, input logic [IW-1:0] idx, input logic [AW-1:0] arg);
    int w = 0;
    cmd_vld = 1'b1; cmd_op = op; cmd_idx = idx; cmd_arg = arg;
    while (!cmd_rdy && w < 50) begin tick(); w++; end
    if (!cmd_rdy) begin
      tests++; fails++;
      $display("FAIL send_rdy: cmd_rdy=%0d required 1 within 50 cycles", cmd_rdy);
    end
    tick();
    cmd_vld = 1'b0; cmd_op = '0; cmd_idx = '0; cmd_arg = '0;
  endtask

  task automatic expect_seq(input logic [1:0] cause, input logic [IW-1:0] idx, input int pulses);
    exp_t e;
    e.cause = cause; e.idx = idx; e.pulses = pulses;
    sb.push_back(e);
    npulse = 0; dbl = 0;
  endtask

  // Scoreboard consumer: waits for stop_vld, pops the expected outcome.
  task automatic wait_stop(input string tag, output int ncyc);
    exp_t e;
    ncyc = 0;
    while (!stop_vld && ncyc < 300) begin tick(); ncyc++; end
    tests++;
    if (!stop_vld) begin
      fails++; $display("FAIL %s_stop_timeout: stop_vld=0 required 1", tag); return;
    end
    if (sb.size() == 0) begin
      fails++; $display("FAIL %s_sb_empty: stop_vld=1 with no expected outcome", tag); return;
    end
    e = sb.pop_front();
    if (stop_cause !== e.cause) begin
      fails++; $display("FAIL %s_cause: got %0d required %0d", tag, stop_cause, e.cause);
    end
    tests++;
    if (npulse !== e.pulses) begin
      fails++; $display("FAIL %s_pulses: got %0d required %0d", tag, npulse, e.pulses);
    end
    if (e.cause == 2'd2) begin
      tests++;
      if (bp_idx !== e.idx) begin
        fails++; $display("FAIL %s_bp_idx: got %0d required %0d", tag, bp_idx, e.idx);
      end
    end
    tests++;
    if (dbl !== 1'b0) begin
      fails++; $display("FAIL %s_spacing: cpu_clk high on consecutive cycles", tag);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({cmd_rdy, cpu_clk, running, stop_vld, stop_cause, bp_idx, bp_en, cmd_err, cyc_cnt} !== '0) begin
      fails++; $display("FAIL reset_outputs: some output nonzero, cyc_cnt=%0d bp_en=%b rdy=%0d",
                        cyc_cnt, bp_en, cmd_rdy);
    end
    rstn = 1'b1;
    tick(); tick();
    tests++;
    if (cmd_rdy !== 1'b1) begin
      fails++; $display("FAIL reset_rdy: cmd_rdy=%0d required 1", cmd_rdy);
    end
  endtask

  task automatic test_step_one();
    int n;
    expect_seq(2'd1, '0, 1);
    send(OP_STEP, '0, 32'd0);
    wait_stop("step0", n);
    tests++;
    if (n !== 2) begin fails++; $display("FAIL step0_latency: got %0d required 2", n); end
    tick();
    tests++;
    if (cyc_cnt !== 32'd1) begin fails++; $display("FAIL step0_cyc: got %0d required 1", cyc_cnt); end
    tests++;
    if (running !== 1'b0) begin fails++; $display("FAIL step0_running: got %0d required 0", running); end
  endtask

  task automatic test_step_n();
    int n;
    expect_seq(2'd1, '0, 5);
    send(OP_STEP, '0, 32'd5);
    tests++;
    if (running !== 1'b1) begin fails++; $display("FAIL step5_running_hi: got %0d required 1", running); end
    wait_stop("step5", n);
    tests++;
    if (n !== 10) begin fails++; $display("FAIL step5_latency: got %0d required 10", n); end
    tick();
    tests++;
    if (running !== 1'b0) begin fails++; $display("FAIL step5_running_lo: got %0d required 0", running); end
    tests++;
    if (cyc_cnt !== 32'd6) begin fails++; $display("FAIL step5_cyc: got %0d required 6", cyc_cnt); end
  endtask

  task automatic test_bp_run();
    int n;
    send(OP_SETBP, 2'd1, 32'h10);
    tests++;
    if (cmd_err !== 1'b0) begin fails++; $display("FAIL setbp_err: got %0d required 0", cmd_err); end
    send(OP_SETBP, 2'd0, 32'h10);
    tests++;
    if (bp_en !== 3'b011) begin fails++; $display("FAIL setbp_en: got %b required 011", bp_en); end
    pc = 32'h0;
    expect_seq(2'd2, 2'd0, 4);
    send(OP_RUN, '0, '0);
    wait_stop("bp_run", n);
  endtask

  task automatic test_bp_skip();
    int n;
    send(OP_CLRBP, 2'd1, '0);
    send(OP_SETBP, 2'd1, 32'h18);
    pc = 32'h10;
    expect_seq(2'd2, 2'd1, 2);
    send(OP_RUN, '0, '0);
    wait_stop("bp_skip", n);
    tests++;
    if (n !== 4) begin fails++; $display("FAIL bp_skip_latency: got %0d required 4", n); end
  endtask

  task automatic test_halt_on_hit();
    int n, w = 0;
    pc = 32'h10;
    expect_seq(2'd3, '0, 2);
    send(OP_RUN, '0, '0);
    while (!(running && cmd_rdy && pc == 32'h18) && w < 50) begin tick(); w++; end
    send(OP_HALT, '0, '0);
    wait_stop("halt_hit", n);
    tests++;
    if (n !== 0) begin fails++; $display("FAIL halt_hit_latency: got %0d required 0", n); end
  endtask

  task automatic test_setbp_midrun();
    int n, w = 0;
    send(OP_CLRALL, '0, '0);
    tests++;
    if ({bp_en, cyc_cnt} !== '0) begin
      fails++; $display("FAIL clrall: bp_en=%b cyc_cnt=%0d required 0/0", bp_en, cyc_cnt);
    end
    pc = 32'h0;
    expect_seq(2'd3, '0, 2);
    send(OP_RUN, '0, '0);
    while (!(running && cmd_rdy) && w < 50) begin tick(); w++; end
    send(OP_SETBP, 2'd2, 32'h40);
    tests++;
    if (cmd_err !== 1'b1) begin fails++; $display("FAIL midrun_err: got %0d required 1", cmd_err); end
    tests++;
    if (bp_en !== 3'b000) begin fails++; $display("FAIL midrun_bp_en: got %b required 000", bp_en); end
    w = 0;
    while (!(running && cmd_rdy) && w < 50) begin tick(); w++; end
    send(OP_HALT, '0, '0);
    wait_stop("midrun", n);
    tick();
    tests++;
    if (cmd_err !== 1'b0) begin fails++; $display("FAIL err_pulse_len: got %0d required 0", cmd_err); end
  endtask

  task automatic test_illegal();
    int n;
    send(OP_SETBP, 2'd1, 32'h20);
    send(OP_RSVD, '0, '0);
    tests++;
    if (cmd_err !== 1'b1) begin fails++; $display("FAIL op7_err: got %0d required 1", cmd_err); end
    send(OP_SETBP, 2'd3, 32'h99);
    tests++;
    if (cmd_err !== 1'b1) begin fails++; $display("FAIL idx_oob_err: got %0d required 1", cmd_err); end
    tests++;
    if (bp_en !== 3'b010) begin fails++; $display("FAIL idx_oob_en: got %b required 010", bp_en); end
    expect_seq(2'd3, '0, 0);
    send(OP_HALT, '0, '0);
    wait_stop("halt_idle", n);
    tests++;
    if (running !== 1'b0) begin fails++; $display("FAIL halt_idle_running: got %0d required 0", running); end
  endtask

  task automatic test_reset_midrun();
    int seen = 0;
    pc = 32'h0;
    send(OP_RUN, '0, '0);
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    tests++;
    if ({cmd_rdy, cpu_clk, running, stop_vld, stop_cause, bp_idx, bp_en, cmd_err, cyc_cnt} !== '0) begin
      fails++; $display("FAIL rst_midrun: outputs nonzero, cyc_cnt=%0d bp_en=%b run=%0d",
                        cyc_cnt, bp_en, running);
    end
    sb.delete();
    repeat (2) begin tick(); if (stop_vld) seen++; end
    rstn = 1'b1;
    pend = 0;
    repeat (6) begin tick(); if (stop_vld || running) seen++; end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL rst_no_stop: stop/run seen %0d times required 0", seen); end
  endtask

  initial begin
    test_reset();
    test_step_one();
    test_step_n();
    test_bp_run();
    test_bp_skip();
    test_halt_on_hit();
    test_setbp_midrun();
    test_illegal();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
